// File: rtl/muldiv_iter_unit.sv
// -----------------------------------------------------------------------------
// muldiv_iter_unit
// Iterative RV32M multiply/divide unit for the EX stage. Bit-serial datapath
// with a fixed latency: XLEN CALC cycles followed by one FIN cycle in which
// `done` pulses and `result`/`rd_out` become valid.
//
// Ports
//   clk     in   1     rising-edge clock
//   reset   in   1     synchronous, active-low
//   start   in   1     launch request (sampled only in IDLE)
//   op      in   3     funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   op_a    in   XLEN  rs1 value
//   op_b    in   XLEN  rs2 value
//   rd_in   in   5     destination tag
//   flush   in   1     abort in-flight operation
//   busy    out  1     high during the XLEN CALC cycles
//   done    out  1     one-cycle pulse in FIN
//   result  out  XLEN  registered result
//   rd_out  out  5     registered destination tag
// -----------------------------------------------------------------------------
module muldiv_iter_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t state_q, state_d;

   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // mc_q: multiplicand (mul) or divisor (div).
   // acc_q: {hi, lo}; mul: lo starts as multiplier, ends as product.
   //        div: lo holds dividend bits shifting out / quotient bits shifting in.
   logic [XLEN-1:0]   mc_q, mc_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic              a_neg_q, a_neg_d;
   logic              b_neg_q, b_neg_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   // Launch decode on raw inputs
   logic            sgn_a_in, sgn_b_in, a_neg_in, b_neg_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in;

   always_comb begin
      sgn_a_in = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      sgn_b_in = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg_in = sgn_a_in & op_a[XLEN-1];
      b_neg_in = sgn_b_in & op_b[XLEN-1];
      a_mag_in = a_neg_in ? (~op_a + 1'b1) : op_a;
      b_mag_in = b_neg_in ? (~op_b + 1'b1) : op_b;
   end

   // One iteration step for each datapath
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] acc_mul_nx;
   logic [XLEN:0]     r_sh, r_diff, rem_nx;
   logic              q_bit;
   logic [2*XLEN-1:0] acc_div_nx;

   always_comb begin
      mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
      acc_mul_nx = {mul_sum, acc_q[XLEN-1:1]};
      r_sh       = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
      r_diff     = r_sh - {1'b0, mc_q};
      q_bit      = (r_sh >= {1'b0, mc_q});
      rem_nx     = q_bit ? r_diff : r_sh;
      acc_div_nx = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
   end

   // Final selection, computed from the last iteration's next values so the
   // result register is loaded on the edge entering FIN.
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo, quo_s, rm, rem_s, fin_val;

   always_comb begin
      prod_s = (a_neg_q ^ b_neg_q) ? (~acc_mul_nx + 1'b1) : acc_mul_nx;
      quo    = acc_div_nx[XLEN-1:0];
      rm     = rem_nx[XLEN-1:0];
      quo_s  = (a_neg_q ^ b_neg_q) ? (~quo + 1'b1) : quo;
      rem_s  = a_neg_q ? (~rm + 1'b1) : rm;
      fin_val = '0;
      case (op_q)
         3'b000:                 fin_val = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_val = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_val = ovf_q ? MIN_VAL : (dz_q ? '1 : quo_s);
         // On divide-by-zero the restoring loop shifts the whole dividend
         // magnitude into the remainder, so sign correction restores op_a.
         default:                fin_val = ovf_q ? '0 : rem_s;
      endcase
   end

   // Next-state and datapath
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rd_out_d = rd_out_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      mc_d     = mc_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            // flush outranks a simultaneous start
            if (start && !flush) begin
               state_d = S_CALC;
               op_d    = op;
               rd_d    = rd_in;
               a_neg_d = a_neg_in;
               b_neg_d = b_neg_in;
               dz_d    = (op_b == '0);
               ovf_d   = op[2] & sgn_b_in & (op_a == MIN_VAL) & (&op_b);
               cnt_d   = CNT_W'(XLEN - 1);
               rem_d   = '0;
               if (op[2]) begin
                  mc_d  = b_mag_in;
                  acc_d = {{XLEN{1'b0}}, a_mag_in};
               end else begin
                  mc_d  = a_mag_in;
                  acc_d = {{XLEN{1'b0}}, b_mag_in};
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[2] ? acc_div_nx : acc_mul_nx;
               rem_d = op_q[2] ? rem_nx : rem_q;
               if (cnt_q == '0) begin
                  state_d  = S_FIN;
                  result_d = fin_val;
                  rd_out_d = rd_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         mc_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rd_out_q <= rd_out_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         mc_q     <= mc_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == S_CALC);
   assign done   = (state_q == S_FIN);
   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
module tb_muldiv_iter_unit;
   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                          DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   muldiv_iter_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result),
      .rd_out(rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; drives a one-cycle start and waits (bounded) for done.
   // Returns at the negedge of the done cycle; lat counts cycles after start.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res,
                         output logic [4:0] rdo, output int lat,
                         output logic busy1, output logic busy_fin);
      start = 1'b1; op = o; op_a = a; op_b = b; rd_in = rd;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      busy1 = busy;
      while (done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      res = result; rdo = rd_out; busy_fin = busy;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b1; op = MUL; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd9; flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h want=0", result); end
      n_cmp++; if (rd_out !== 5'd0)  begin n_err++; $display("FAIL reset_rd_out got=%0d want=0", rd_out); end
      start = 1'b0; reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_mul();
      logic [31:0] r; logic [4:0] rdo; int lat; logic b1, bf;
      run_op(MUL, 32'd7, 32'hFFFFFFFD, 5'd5, r, rdo, lat, b1, bf);
      n_cmp++; if (lat !== 33)          begin n_err++; $display("FAIL mul_latency got=%0d want=33", lat); end
      n_cmp++; if (r !== 32'hFFFFFFEB)  begin n_err++; $display("FAIL mul_result got=%h want=ffffffeb", r); end
      n_cmp++; if (rdo !== 5'd5)        begin n_err++; $display("FAIL mul_rd_out got=%0d want=5", rdo); end
      n_cmp++; if (b1 !== 1'b1)         begin n_err++; $display("FAIL mul_busy_calc got=%b want=1", b1); end
      n_cmp++; if (bf !== 1'b0)         begin n_err++; $display("FAIL mul_busy_fin got=%b want=0", bf); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL mul_done_pulse got=%b want=0", done); end
      n_cmp++; if (result !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul_hold got=%h want=ffffffeb", result); end
      run_op(MULH, 32'h80000000, 32'h80000000, 5'd6, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'h40000000)  begin n_err++; $display("FAIL mulh got=%h want=40000000", r); end
      @(negedge clk);
      run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFE)  begin n_err++; $display("FAIL mulhu got=%h want=fffffffe", r); end
      @(negedge clk);
      run_op(MULHSU, 32'hFFFFFFFF, 32'd2, 5'd8, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL mulhsu got=%h want=ffffffff", r); end
      @(negedge clk);
   endtask

   task automatic test_div();
      logic [31:0] r; logic [4:0] rdo; int lat; logic b1, bf;
      run_op(DIVU, 32'd100, 32'd7, 5'd1, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd14)        begin n_err++; $display("FAIL divu got=%h want=0000000e", r); end
      n_cmp++; if (lat !== 33)          begin n_err++; $display("FAIL divu_latency got=%0d want=33", lat); end
      @(negedge clk);
      run_op(REMU, 32'd100, 32'd7, 5'd2, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd2)         begin n_err++; $display("FAIL remu got=%h want=00000002", r); end
      @(negedge clk);
      run_op(DIV, 32'hFFFFFFF9, 32'd2, 5'd3, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFD)  begin n_err++; $display("FAIL div_neg got=%h want=fffffffd", r); end
      @(negedge clk);
      run_op(REM, 32'hFFFFFFF9, 32'd2, 5'd4, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL rem_neg got=%h want=ffffffff", r); end
      @(negedge clk);
      run_op(DIV, 32'd7, 32'hFFFFFFFE, 5'd5, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFD)  begin n_err++; $display("FAIL div_negdivisor got=%h want=fffffffd", r); end
      @(negedge clk);
      run_op(REM, 32'd7, 32'hFFFFFFFE, 5'd6, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd1)         begin n_err++; $display("FAIL rem_negdivisor got=%h want=00000001", r); end
      @(negedge clk);
   endtask

   task automatic test_special();
      logic [31:0] r; logic [4:0] rdo; int lat; logic b1, bf;
      run_op(DIV, 32'd5, 32'd0, 5'd10, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL div_by_zero got=%h want=ffffffff", r); end
      n_cmp++; if (lat !== 33)          begin n_err++; $display("FAIL div_by_zero_latency got=%0d want=33", lat); end
      @(negedge clk);
      run_op(REM, 32'd5, 32'd0, 5'd11, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd5)         begin n_err++; $display("FAIL rem_by_zero got=%h want=00000005", r); end
      @(negedge clk);
      run_op(DIV, 32'hFFFFFFFB, 32'd0, 5'd12, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL div_neg_by_zero got=%h want=ffffffff", r); end
      @(negedge clk);
      run_op(REM, 32'hFFFFFFFB, 32'd0, 5'd13, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFB)  begin n_err++; $display("FAIL rem_neg_by_zero got=%h want=fffffffb", r); end
      @(negedge clk);
      run_op(DIVU, 32'd5, 32'd0, 5'd14, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFF)  begin n_err++; $display("FAIL divu_by_zero got=%h want=ffffffff", r); end
      @(negedge clk);
      run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd15, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'h80000000)  begin n_err++; $display("FAIL div_overflow got=%h want=80000000", r); end
      n_cmp++; if (lat !== 33)          begin n_err++; $display("FAIL div_overflow_latency got=%0d want=33", lat); end
      @(negedge clk);
      run_op(REM, 32'h80000000, 32'hFFFFFFFF, 5'd16, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd0)         begin n_err++; $display("FAIL rem_overflow got=%h want=00000000", r); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      logic [31:0] r; logic [4:0] rdo; int lat; logic b1, bf; int cyc; logic saw_done;
      run_op(MUL, 32'd6, 32'd7, 5'd2, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd42)        begin n_err++; $display("FAIL flush_pre_mul got=%h want=0000002a", r); end
      @(negedge clk);
      start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
      @(negedge clk);
      start = 1'b0; cyc = 1; saw_done = 1'b0;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) saw_done = 1'b1;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL flush_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0 || saw_done) begin n_err++; $display("FAIL flush_done got=%b want=0", done | saw_done); end
      n_cmp++; if (result !== 32'd42)   begin n_err++; $display("FAIL flush_result_kept got=%h want=0000002a", result); end
      n_cmp++; if (rd_out !== 5'd2)     begin n_err++; $display("FAIL flush_rd_kept got=%0d want=2", rd_out); end
      run_op(REMU, 32'd100, 32'd7, 5'd17, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'd2 || rdo !== 5'd17) begin n_err++; $display("FAIL flush_relaunch got=%h/%0d want=00000002/17", r, rdo); end
      n_cmp++; if (lat !== 33)          begin n_err++; $display("FAIL flush_relaunch_latency got=%0d want=33", lat); end
      @(negedge clk);
   endtask

   task automatic test_drop();
      int cyc; int first_done; int n_done;
      start = 1'b1; op = MUL; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd3;
      @(negedge clk);
      start = 1'b0; cyc = 1; first_done = 0; n_done = 0;
      while (cyc < 80) begin
         if (cyc == 5) begin
            start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd4;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (done === 1'b1) begin
            n_done++;
            if (first_done == 0) begin
               first_done = cyc;
               n_cmp++; if (result !== 32'd42 || rd_out !== 5'd3) begin n_err++; $display("FAIL drop_result got=%h/%0d want=0000002a/3", result, rd_out); end
            end
         end
      end
      n_cmp++; if (first_done !== 33)   begin n_err++; $display("FAIL drop_latency got=%0d want=33", first_done); end
      n_cmp++; if (n_done !== 1)        begin n_err++; $display("FAIL drop_done_count got=%0d want=1", n_done); end
   endtask

   task automatic test_reset_mid();
      int cyc; logic saw_done;
      start = 1'b1; op = MUL; op_a = 32'h0000FFFF; op_b = 32'h0000FFFF; rd_in = 5'd7;
      @(negedge clk);
      start = 1'b0; cyc = 1; saw_done = 1'b0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midreset_ctrl got=%b%b want=00", busy, done); end
      n_cmp++; if (result !== 32'd0 || rd_out !== 5'd0) begin n_err++; $display("FAIL midreset_out got=%h/%0d want=00000000/0", result, rd_out); end
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_cmp++; if (saw_done !== 1'b0)   begin n_err++; $display("FAIL midreset_no_done got=%b want=0", saw_done); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic [4:0] rdo; int lat; logic b1, bf;
      @(negedge clk);
      run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFE || rdo !== 5'd20) begin n_err++; $display("FAIL b2b_first got=%h/%0d want=fffffffe/20", r, rdo); end
      @(negedge clk);
      run_op(DIV, 32'hFFFFFFF9, 32'd2, 5'd21, r, rdo, lat, b1, bf);
      n_cmp++; if (r !== 32'hFFFFFFFD || rdo !== 5'd21) begin n_err++; $display("FAIL b2b_second got=%h/%0d want=fffffffd/21", r, rdo); end
      n_cmp++; if (lat !== 33)          begin n_err++; $display("FAIL b2b_latency got=%0d want=33", lat); end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
